// File: rtl/bcd_down_counter.sv
// Loadable packed-BCD countdown counter with tick prescaler and IDLE/RUN/PAUSED/DONE control.
// Emits a one-cycle done pulse on reaching zero and a one-cycle load_err pulse on a bad preset.
module bcd_down_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StDone
    } state_e;

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_dec;
    logic [PW-1:0] presc_q;
    logic          done_q;
    logic          load_err_q;
    logic          load_ok;
    logic          count_ok;
    logic          borrow;
    logic          tick;

    // Preset is accepted only when every nibble is a legal decimal digit.
    always_comb begin
        load_ok  = 1'b1;
        count_ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_value[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
            if (count_q[4*i +: 4] > 4'd9) begin
                count_ok = 1'b0;
            end
        end
    end

    // Ripple-borrow BCD decrement; a zero digit becomes 9 and borrows upward.
    always_comb begin
        count_dec = count_q;
        borrow    = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    assign tick = (presc_q == PrescLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            presc_q    <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count_q <= load_value;
                    presc_q <= '0;
                    state_q <= StIdle;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (count_q == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StRun;
                                presc_q <= '0;
                            end
                        end
                    end
                    // The pause edge is still a RUN cycle, so the prescaler advances on it.
                    StRun: begin
                        if (tick) begin
                            presc_q <= '0;
                            count_q <= count_dec;
                            if (count_dec == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else if (pause) begin
                                state_q <= StPaused;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                            if (pause) begin
                                state_q <= StPaused;
                            end
                        end
                    end
                    StPaused: begin
                        if (start) begin
                            state_q <= StRun;
                        end
                    end
                    StDone: begin
                        state_q <= StDone;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign count    = count_q;
    assign busy     = (state_q == StRun) || (state_q == StPaused);
    assign done     = done_q;
    assign load_err = load_err_q;

    a_count_bcd: assert property (@(posedge clk) disable iff (reset) count_ok);
    a_done_not_busy: assert property (@(posedge clk) disable iff (reset) !(done_q && busy));

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: DIGITS=2 with TICK_DIV=4 and TICK_DIV=1 instances.
module tb_bcd_down_counter;

    logic       clk;
    logic       reset;
    logic       load, start, pause;
    logic [7:0] load_value;
    logic [7:0] count;
    logic       busy, done, load_err;
    logic       load1, start1, pause1;
    logic [7:0] load_value1;
    logic [7:0] count1;
    logic       busy1, done1, load_err1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       st;
        logic       ps;
        logic [7:0] c;
        logic       b;
        logic       d;
        logic       e;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic       b;
        logic       d;
        logic       e;
        string      nm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];

    bcd_down_counter #(.DIGITS(2), .TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err)
    );

    bcd_down_counter #(.DIGITS(2), .TICK_DIV(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .load       (load1),
        .load_value (load_value1),
        .start      (start1),
        .pause      (pause1),
        .count      (count1),
        .busy       (busy1),
        .done       (done1),
        .load_err   (load_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [7:0] lv, input logic st,
                                input logic ps, input logic [7:0] c, input logic b,
                                input logic d, input logic e);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.ps = ps;
        v.c = c; v.b = b; v.d = d; v.e = e;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
    task automatic step(input bit sel, input logic ld, input logic [7:0] lv, input logic st,
                        input logic ps, input logic [7:0] ec, input logic eb, input logic ed,
                        input logic ee, input string nm);
        exp_t x;
        exp_t y;
        if (sel) begin
            load1 = ld; load_value1 = lv; start1 = st; pause1 = ps;
        end else begin
            load = ld; load_value = lv; start = st; pause = ps;
        end
        x.c = ec; x.b = eb; x.d = ed; x.e = ee; x.nm = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        if (sel) begin
            check({y.nm, " count"}, count1, y.c);
            check({y.nm, " busy"}, 8'(busy1), 8'(y.b));
            check({y.nm, " done"}, 8'(done1), 8'(y.d));
            check({y.nm, " load_err"}, 8'(load_err1), 8'(y.e));
        end else begin
            check({y.nm, " count"}, count, y.c);
            check({y.nm, " busy"}, 8'(busy), 8'(y.b));
            check({y.nm, " done"}, 8'(done), 8'(y.d));
            check({y.nm, " load_err"}, 8'(load_err), 8'(y.e));
        end
        load = 1'b0; start = 1'b0; pause = 1'b0;
        load1 = 1'b0; start1 = 1'b0; pause1 = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 8'h12, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 8'h1A, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 8'hA0, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        tbl[4]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 8'h02, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 8'h12, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        load = 1'b0; start = 1'b0; pause = 1'b0; load_value = 8'h00;
        load1 = 1'b0; start1 = 1'b0; pause1 = 1'b0; load_value1 = 8'h00;
        #3;
        check("reset count", count, 8'h00);
        check("reset busy", 8'(busy), 8'h00);
        check("reset done", 8'(done), 8'h00);
        check("reset load_err", 8'(load_err), 8'h00);
        check("reset count1", count1, 8'h00);
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].ps,
                 tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Countdown from 12: one step per 4 cycles, done 48 cycles after start.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, "cd12 start");
        for (int k = 1; k <= 48; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, to_bcd(12 - k / 4), k < 48, k == 48, 1'b0,
                 $sformatf("cd12 k%0d", k));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "cd12 after");

        // Pause at count 04, hold 20 cycles, resume with start and pause together.
        step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, "p load05");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, "p start");
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, to_bcd(5 - k / 4), 1'b1, 1'b0, 1'b0,
                 $sformatf("p run k%0d", k));
        end
        for (int k = 6; k <= 25; k++) begin
            if (k == 15) begin
                step(1'b0, 1'b1, 8'h1A, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, "p badload");
            end else begin
                step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0,
                     $sformatf("p hold k%0d", k));
            end
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, "p resume");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, "p r+1");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, "p r+2");
        for (int k = 3; k <= 5; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0,
                 $sformatf("p r+%0d", k));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, "p r+6");

        // Load while running returns to IDLE; then async reset at count 27.
        step(1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "r load30");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, "r start");
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, to_bcd(30 - k / 4), 1'b1, 1'b0, 1'b0,
                 $sformatf("r run k%0d", k));
        end
        #2;
        reset = 1'b1;
        #1;
        check("r async count", count, 8'h00);
        check("r async busy", 8'(busy), 8'h00);
        check("r async done", 8'(done), 8'h00);
        @(posedge clk);
        #1;
        check("r held count", count, 8'h00);
        check("r held done", 8'(done), 8'h00);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "r post");
        step(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "r load02+start");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "r idle");

        // TICK_DIV=1: decrement every cycle from 99.
        step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, "t1 load99");
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, "t1 start");
        for (int k = 1; k <= 99; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, to_bcd(99 - k), k < 99, k == 99, 1'b0,
                 $sformatf("t1 k%0d", k));
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t1 after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Loadable multi-digit BCD countdown counter with a built-in tick prescaler. Decrements toward zero instead of counting up.
- Used by the calculator for timed operations and display countdowns. Its packed BCD output feeds the display digit-scan path directly.
- A small state machine (IDLE/RUN/PAUSED/DONE) controls it and emits a one-cycle terminal pulse on reaching zero.

Parameters:
DIGITS, 4, number of BCD digits; count width = 4*DIGITS
TICK_DIV, 100000, clk cycles per decrement (>=1); prescaler width = clog2(TICK_DIV), min 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clock clk
load  input  1  load load_value, synchronous, sampled each edge
load_value  input  4*DIGITS  packed BCD preset, digit 0 = bits [3:0]
start  input  1  begin/resume countdown
pause  input  1  suspend countdown
count  output  4*DIGITS  current packed BCD value (registered)
busy  output  1  high in RUN or PAUSED
done  output  1  one-cycle pulse on reaching zero
load_err  output  1  one-cycle pulse when load is rejected

Behaviour:
- Reset (async): count=0, prescaler=0, state=IDLE, busy=0, done=0, load_err=0. Reset mid-run aborts immediately; no done pulse.
- States:
  - IDLE: holds count.
  - RUN: prescaler advances every cycle.
  - PAUSED: prescaler and count frozen.
  - DONE: count held at 0.
- Priority per edge: load > start > pause.
- load, any state:
  - If every digit of load_value is <=9: count<=load_value, prescaler<=0, state<=IDLE.
  - If any digit is >9: load_err=1 for one cycle; count, state and prescaler unchanged.
  - In both cases start and pause in the same cycle are ignored.
- start:
  - IDLE with count!=0: go to RUN, prescaler<=0.
  - IDLE with count==0: go straight to DONE with a done pulse.
  - PAUSED: go to RUN; prescaler resumes from its held value.
  - RUN or DONE: ignored.
- pause in RUN: go to PAUSED. Ignored in all other states.
- Prescaler in RUN: counts 0..TICK_DIV-1, then wraps to 0. On the wrap edge a tick decrements count.
- First decrement lands TICK_DIV cycles after the start edge. TICK_DIV=1 decrements every cycle.
- BCD decrement: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. All digits stay in 0..9 at all times; binary wrap (e.g. to F) is forbidden.
- Terminal: on the tick edge where count goes from 1 to 0:
  - state<=DONE and done=1 for exactly that one following cycle.
  - No decrement below zero, ever.
- DONE: count stays 0, busy=0. Leave DONE only via load (to IDLE) or reset.
- busy is combinational from state or registered; either way it must be valid in the cycle after the transition edge.
- done and load_err are registered single-cycle pulses that never stretch.
- pause held high continuously: stays PAUSED until start. start and pause asserted together in PAUSED: start wins, go to RUN.

Test Plan:
- Sim config DIGITS=2, TICK_DIV=4.
- reset, load=1 load_value=8'h12, then start -> count 12,11,10,09,...,01,00 with one step every 4 cycles. 10->09 borrow is exact; no 0F. done pulses once, 48 cycles after the start edge; busy falls in the same cycle done rises.
- load 8'h05, start, pause after 6 cycles (count=04), hold pause 20 cycles, then start -> count frozen at 04 during pause. Resumes with preserved prescaler phase; next decrement lands 2 cycles after resume.
- load 8'h1A -> load_err=1 for 1 cycle, count unchanged, state unchanged. load 8'hA0 likewise rejected.
- load 8'h00, start -> DONE next edge with done=1 for one cycle; busy never asserts.
- load 8'h30, start, assert reset asynchronously mid-cycle at count=27 -> count=0, busy=0 immediately, no done pulse. Then load 8'h02 and start in the same cycle -> loads 02, stays IDLE, start ignored.
- TICK_DIV=1 build: load 8'h99, start -> decrements every cycle to 00 over 99 cycles; done pulses exactly once.
